// File: rtl/pes_reverse_pipe.sv
// pes_reverse_pipe: 2-entry FIFO that stores a bit/group permutation of each accepted word.
// Ports: clk, nrst (async low), in_valid/in_ready/in_data/in_mode, out_valid/out_ready/out_data, busy.
// Optional: define PES_REVERSE_PIPE_STATS_EN to add xfer_count (32-bit output transfer count).
//
// Modes: 0 pass-through, 1 reverse all bits,
// 2 reverse GROUP-bit group order, 3 reverse bits within each group.
// slot0_q is always the head; out_data reads it directly.
// in_ready is a flop so it has no path from in_valid or out_ready.

module pes_reverse_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef PES_REVERSE_PIPE_STATS_EN
  ,
  output logic [31:0]      xfer_count
`endif
);

  localparam int NG = (GROUP > 0) ? WIDTH / GROUP : 1;

  if (WIDTH < 2 || GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_cfg
    $error("pes_reverse_pipe: WIDTH>=2, GROUP>=1, GROUP must divide WIDTH");
  end

  function automatic logic [WIDTH-1:0] permute(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m
  );
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      2'd1: begin
        for (int i = 0; i < WIDTH; i++) begin
          r[i] = d[WIDTH-1-i];
        end
      end
      2'd2: begin
        for (int g = 0; g < NG; g++) begin
          r[g*GROUP +: GROUP] = d[(NG-1-g)*GROUP +: GROUP];
        end
      end
      2'd3: begin
        for (int g = 0; g < NG; g++) begin
          for (int b = 0; b < GROUP; b++) begin
            r[g*GROUP+b] = d[g*GROUP+GROUP-1-b];
          end
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic [WIDTH-1:0] slot0_q;
  logic [WIDTH-1:0] slot0_d;
  logic [WIDTH-1:0] slot1_q;
  logic [WIDTH-1:0] slot1_d;
  logic             ready_q;
  logic             ready_d;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] perm;

  assign out_valid = (count_q != 2'd0);
  assign busy      = out_valid;
  assign in_ready  = ready_q;
  assign out_data  = slot0_q;

  assign push = in_valid & ready_q;
  assign pop  = out_valid & out_ready;
  assign perm = permute(in_data, in_mode);

  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (push && pop) begin
      // Only reachable with one word stored: new word becomes head.
      slot0_d = perm;
    end else if (push) begin
      count_d = count_q + 2'd1;
      if (count_q == 2'd0) begin
        slot0_d = perm;
      end else begin
        slot1_d = perm;
      end
    end else if (pop) begin
      count_d = count_q - 2'd1;
      slot0_d = slot1_q;
    end
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      ready_q <= ready_d;
    end
  end

`ifdef PES_REVERSE_PIPE_STATS_EN
  logic [31:0] xfer_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      xfer_q <= 32'd0;
    end else if (pop) begin
      xfer_q <= xfer_q + 32'd1;
    end
  end

  assign xfer_count = xfer_q;
`endif

endmodule

// File: tb/tb_pes_reverse_pipe.sv
// tb_pes_reverse_pipe: scoreboard bench for pes_reverse_pipe.
// Two instances: 16/8 (main) and 15/5 (odd width/group).

module tb_pes_reverse_pipe;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;

  logic        v_in_valid = 1'b0;
  logic        v_in_ready;
  logic [14:0] v_in_data = '0;
  logic [1:0]  v_in_mode = '0;
  logic        v_out_valid;
  logic        v_out_ready = 1'b1;
  logic [14:0] v_out_data;
  logic        v_busy;

`ifdef PES_REVERSE_PIPE_STATS_EN
  logic [31:0] xfer_count;
  logic [31:0] v_xfer_count;
`endif

  pes_reverse_pipe #(.WIDTH(16), .GROUP(8)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
`ifdef PES_REVERSE_PIPE_STATS_EN
    , .xfer_count(xfer_count)
`endif
  );

  pes_reverse_pipe #(.WIDTH(15), .GROUP(5)) dut15 (
    .clk(clk), .nrst(nrst),
    .in_valid(v_in_valid), .in_ready(v_in_ready),
    .in_data(v_in_data), .in_mode(v_in_mode),
    .out_valid(v_out_valid), .out_ready(v_out_ready),
    .out_data(v_out_data), .busy(v_busy)
`ifdef PES_REVERSE_PIPE_STATS_EN
    , .xfer_count(v_xfer_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int pops = 0;
  logic [15:0] q[$];
  logic [14:0] q15[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Source-to-destination mapping model, 16-bit, GROUP=8.
  function automatic logic [15:0] model(input logic [15:0] d,
                                        input logic [1:0] m);
    logic [15:0] r;
    int grp, b, dst;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      grp = i / 8;
      b = i % 8;
      case (m)
        2'd1: dst = 15 - i;
        2'd2: dst = (1 - grp) * 8 + b;
        2'd3: dst = grp * 8 + (7 - b);
        default: dst = i;
      endcase
      r[dst] = d[i];
    end
    return r;
  endfunction

  // Monitors: compare each output transfer with the queue head.
  always @(negedge clk) begin
    if (nrst && out_valid && out_ready) begin
      pops++;
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out: got %h expected none", out_data);
      end else begin
        chk("out_data", {16'd0, out_data}, {16'd0, q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (nrst && v_out_valid && v_out_ready) begin
      if (q15.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out15: got %h expected none", v_out_data);
      end else begin
        chk("out_data15", {17'd0, v_out_data}, {17'd0, q15.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] m,
                      input logic [15:0] e);
    int n;
    n = 0;
    q.push_back(e);
    in_valid = 1'b1;
    in_data = d;
    in_mode = m;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        $display("FAIL send_timeout: got in_ready 0 expected 1");
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e[4];
    int p0, bad;
    e = '{16'h1234, 16'h2C48, 16'h3412, 16'h482C};

    // Reset state while nrst low.
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    nrst = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Four modes, one-cycle latency.
    for (int m = 0; m < 4; m++) begin
      send(16'h1234, m[1:0], e[m]);
      @(negedge clk);
      chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end

    // Odd width/group instance.
    chk("w15_in_ready", {31'd0, v_in_ready}, 32'd1);
    q15.push_back(15'h4000);
    v_in_valid = 1'b1;
    v_in_data = 15'h0001;
    v_in_mode = 2'd1;
    tick();
    q15.push_back(15'h7C00);
    v_in_data = 15'h001F;
    v_in_mode = 2'd2;
    tick();
    v_in_valid = 1'b0;
    repeat (2) tick();

    // Backpressure: A,B stored, C held.
    out_ready = 1'b0;
    send(16'hA5A5, 2'd0, 16'hA5A5);
    send(16'h00FF, 2'd1, 16'hFF00);
    q.push_back(16'h3412);
    in_valid = 1'b1;
    in_data = 16'h1234;
    in_mode = 2'd2;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_data", {16'd0, out_data}, 32'h0000A5A5);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_cycle_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("count1_swap_busy", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("bp_drained", q.size(), 32'd0);
    tick();

    // Sustained stream of 100 random words.
    p0 = pops;
    bad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 16'($urandom);
      in_mode = 2'($urandom_range(0, 3));
      q.push_back(model(in_data, in_mode));
      @(negedge clk);
      if (!in_ready) bad++;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("stream_pops", pops - p0, 32'd100);
    chk("stream_stalls", bad, 32'd0);
    tick();

`ifdef PES_REVERSE_PIPE_STATS_EN
    chk("xfer_count_107", xfer_count, 32'd107);
`endif

    // Reset with two words stored.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'hDEAD;
    in_mode = 2'd0;
    tick();
    in_data = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd0);
    chk("async_out_data", {16'd0, out_data}, 32'd0);
    tick();
    nrst = 1'b1;
    out_ready = 1'b1;
    p0 = pops;
    repeat (5) tick();
    chk("no_stale_pops", pops - p0, 32'd0);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef PES_REVERSE_PIPE_STATS_EN
    chk("xfer_count_rst", xfer_count, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(16'h0F0F, 2'd0, 16'h0F0F);
    end
    tick();
    chk("xfer_count_5", xfer_count, 32'd5);
    force dut.xfer_q = 32'hFFFFFFFF;
    #1;
    release dut.xfer_q;
    send(16'h0001, 2'd1, 16'h8000);
    tick();
    chk("xfer_count_wrap", xfer_count, 32'd0);
`endif

    repeat (2) tick();
    chk("q_empty", q.size(), 32'd0);
    chk("q15_empty", q15.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
